// File: rtl/rr_merge_arb_pkg.sv
// Native IOb bus geometry (shared interconnect macros) and the arbiter state type.
// The macros are guarded so a project-wide interconnect header can supply them instead.
`ifndef IOB_INTERCONNECT_VH
`define IOB_INTERCONNECT_VH
`define VALID_W 1
`define ADDR_W 32
`define DATA_W 32
`define STRB_W 4
`define READY_W 1
`define REQ_W (`VALID_W+`ADDR_W+`DATA_W+`STRB_W)
`define RESP_W (`DATA_W+`READY_W)
`define REQ(I) ((I)+1)*`REQ_W-1 -: `REQ_W
`define RESP(I) ((I)+1)*`RESP_W-1 -: `RESP_W
`define VALID_BIT (`REQ_W-1)
`define READY_BIT 0
`endif

package rr_merge_arb_pkg;

    localparam int REQ_W     = `REQ_W;
    localparam int RESP_W    = `RESP_W;
    localparam int VALID_POS = `VALID_BIT;
    localparam int READY_POS = `READY_BIT;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Absolute bit position of master i's valid flag in the concatenated request bus.
    function automatic int valid_pos(input int i);
        return i * REQ_W + VALID_POS;
    endfunction

endpackage

// File: rtl/rr_merge_arb_if.sv
// Bundle of the master-side and slave-side IOb buses plus arbiter status.
interface rr_merge_arb_if #(
    parameter int N_MASTERS = 2
);
    localparam int P_MASTERS = $clog2(N_MASTERS);

    logic [N_MASTERS*`REQ_W-1:0]  m_req;
    logic [N_MASTERS*`RESP_W-1:0] m_resp;
    logic [`REQ_W-1:0]            s_req;
    logic [`RESP_W-1:0]           s_resp;
    logic [P_MASTERS-1:0]         grant;
    logic                         busy;

    // Arbiter side
    modport slave (
        input  m_req, s_resp,
        output m_resp, s_req, grant, busy
    );

    // Environment side: masters plus the shared slave
    modport master (
        output m_req, s_resp,
        input  m_resp, s_req, grant, busy
    );
endinterface

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set bit of req scanning last+1, last+2, ... mod N_MASTERS.
module rr_pick #(
    parameter int N_MASTERS = 2,
    localparam int P_MASTERS = $clog2(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] req,
    input  logic [P_MASTERS-1:0] last,
    output logic                 found,
    output logic [P_MASTERS-1:0] idx
);

    // NOTE: every output gets a default before the loop, otherwise the
    // "nothing requested" path would infer latches on found and idx.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        // Modulo keeps non-power-of-2 counts from ever producing an index >= N_MASTERS.
        for (int k = 1; k <= N_MASTERS; k++) begin
            if (!found && req[(int'(last) + k) % N_MASTERS]) begin
                found = 1'b1;
                idx   = P_MASTERS'((int'(last) + k) % N_MASTERS);
            end
        end
    end

endmodule

// File: rtl/rr_merge_arb.sv
// Round-robin merge of N_MASTERS IOb masters onto one shared slave; the grant is held
// for a whole transaction and released on slave ready or master abort.
module rr_merge_arb
    import rr_merge_arb_pkg::*;
#(
    parameter int N_MASTERS = 2
) (
    input logic         clk,
    input logic         rst_n,
    rr_merge_arb_if.slave bus
);

    localparam int P_MASTERS = $clog2(N_MASTERS);

    state_t                 state_q, state_d;
    logic [P_MASTERS-1:0]   grant_q, grant_d;
    logic [P_MASTERS-1:0]   last_q, last_d;
    logic [N_MASTERS-1:0]   valid_vec;
    logic                   pick_found;
    logic [P_MASTERS-1:0]   pick_idx;
    logic [RESP_W-1:0]      slave_resp;

    for (genvar i = 0; i < N_MASTERS; i++) begin : g_valid
        assign valid_vec[i] = bus.m_req[valid_pos(i)];
    end

    assign slave_resp = bus.s_resp;

    rr_pick #(.N_MASTERS(N_MASTERS)) u_pick (
        .req   (valid_vec),
        .last  (last_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= P_MASTERS'(N_MASTERS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Valid only reaches the grant register through the pick, so grant stays registered.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d = pick_idx;
                    last_d  = pick_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                // Completion or abort both release; the pointer already moved at grant time.
                if (slave_resp[READY_POS] || !valid_vec[grant_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.s_req  = '0;
        bus.m_resp = '0;
        if (state_q == BUSY) begin
            bus.s_req                          = bus.m_req[`REQ(int'(grant_q))];
            bus.m_resp[`RESP(int'(grant_q))]   = slave_resp;
        end
    end

    assign bus.grant = grant_q;
    assign bus.busy  = (state_q == BUSY);

    a_grant_range : assert property (@(posedge clk) disable iff (!rst_n)
        int'(grant_q) < N_MASTERS && int'(last_q) < N_MASTERS);

endmodule
